// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: zero operands / zero divisor bypass the iteration loop.
module muldiv_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            io_req_valid,
  output logic            io_req_ready,
  input  logic [2:0]      io_req_fn,
  input  logic [XLEN-1:0] io_req_in1,
  input  logic [XLEN-1:0] io_req_in2,
  input  logic            io_kill,
  output logic            io_resp_valid,
  input  logic            io_resp_ready,
  output logic [XLEN-1:0] io_resp_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN);

  state_t            state_reg, state_next;
  logic [2:0]        fn_reg;
  logic [XLEN-1:0]   a_reg, b_reg, lo_reg, acc_reg, resp_data_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              neg_q_reg, neg_r_reg;

  logic              accept, is_div, in1_signed, in2_signed, in1_neg, in2_neg;
  logic [XLEN-1:0]   abs1, abs2;
  logic [XLEN-1:0]   mul_addend, acc_next, lo_next, result;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_full, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  assign accept     = io_req_valid && (state_reg == IDLE) && !io_kill;
  assign is_div     = io_req_fn[2];
  assign in1_signed = (io_req_fn == 3'd1) || (io_req_fn == 3'd2) || (io_req_fn == 3'd4) || (io_req_fn == 3'd6);
  assign in2_signed = (io_req_fn == 3'd1) || (io_req_fn == 3'd4) || (io_req_fn == 3'd6);
  assign in1_neg    = in1_signed && io_req_in1[XLEN-1];
  assign in2_neg    = in2_signed && io_req_in2[XLEN-1];
  assign abs1       = in1_neg ? -io_req_in1 : io_req_in1;
  assign abs2       = in2_neg ? -io_req_in2 : io_req_in2;

`ifdef MULDIV_EARLY_OUT_EN
  logic            early_out;
  logic [XLEN-1:0] early_data;
  assign early_out  = is_div ? (io_req_in2 == '0) : ((io_req_in1 == '0) || (io_req_in2 == '0));
  assign early_data = !is_div ? '0 : (io_req_fn[1] ? io_req_in1 : '1);
`endif

  // Multiply: lo_reg holds the multiplier and shifts out LSB-first while product bits shift in.
  assign mul_addend = lo_reg[0] ? a_reg : {XLEN{1'b0}};
  assign mul_sum    = {1'b0, acc_reg} + {1'b0, mul_addend};
  // Divide: lo_reg holds the dividend, shifts out MSB-first while quotient bits shift in.
  assign div_shift  = {acc_reg, lo_reg[XLEN-1]};
  assign div_diff   = div_shift - {1'b0, b_reg};

  assign acc_next = fn_reg[2] ? (div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0])
                              : mul_sum[XLEN:1];
  assign lo_next  = fn_reg[2] ? {lo_reg[XLEN-2:0], ~div_diff[XLEN]}
                              : {mul_sum[0], lo_reg[XLEN-1:1]};

  assign prod_full = {acc_reg, lo_reg};
  assign prod_fix  = neg_q_reg ? -prod_full : prod_full;
  assign quot_fix  = neg_q_reg ? -lo_reg : lo_reg;
  assign rem_fix   = neg_r_reg ? -acc_reg : acc_reg;

  always_comb begin
    result = '0;
    case (fn_reg)
      3'd0:             result = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: result = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:       result = quot_fix;
      default:          result = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
`ifdef MULDIV_EARLY_OUT_EN
          if (early_out) state_next = DONE;
`endif
        end
      end
      BUSY: begin
        if (io_kill)              state_next = IDLE;
        else if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        if (io_kill || io_resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fn_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      lo_reg        <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      resp_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            fn_reg    <= io_req_fn;
            a_reg     <= abs1;
            b_reg     <= abs2;
            lo_reg    <= is_div ? abs1 : abs2;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            // A zero divisor must still yield an all-ones quotient, so never negate it.
            neg_q_reg <= (in1_neg ^ in2_neg) && (!is_div || (io_req_in2 != '0));
            neg_r_reg <= in1_neg;
`ifdef MULDIV_EARLY_OUT_EN
            if (early_out) resp_data_reg <= early_data;
`endif
          end
        end
        BUSY: begin
          if (!io_kill) begin
            if (cnt_reg == LAST) begin
              resp_data_reg <= result;
            end else begin
              acc_reg <= acc_next;
              lo_reg  <= lo_next;
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io_req_ready  = (state_reg == IDLE);
  assign io_resp_valid = (state_reg == DONE);
  assign io_resp_data  = resp_data_reg;

endmodule
